exu_muldiv: RTL and testbench

- Parametrised iterative multiply/divide execution unit for the RV32M/RV64M M-extension instructions.
- Sits beside the single-cycle EXU. The EXU hands off M-extension operations over a valid/ready handshake and stalls until this unit accepts them.
- Each result returns to writeback over a second valid/ready handshake.
- Generalises the EXU datapath in width (XLEN), adds multi-cycle sequencing, back-pressure and flush.

---
 rtl/exu_muldiv.sv | 180 ++++++++++++++++++
 tb/tb_exu_muldiv.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv.sv
// ============================================================================
// Module   : exu_muldiv
// Brief    : Iterative RV32M/RV64M multiply/divide unit with valid/ready
//            handshakes, back-pressure and flush. Optional single-cycle
//            multiply when CIRNO_MULDIV_FASTMUL_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exu_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hs_ex4md_val,
    output logic            hs_md4ex_rdy,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd_idx,
    input  logic            i_flush,
    output logic            hs_md4wb_val,
    input  logic            hs_wb4md_rdy,
    output logic [XLEN-1:0] o_rd,
    output logic [4:0]      o_rd_idx
);

    localparam int W2 = 2 * XLEN;

    localparam logic [2:0] c_MUL  = 3'd0;
    localparam logic [2:0] c_MULH = 3'd1;
    localparam logic [2:0] c_DIV  = 3'd4;
    localparam logic [2:0] c_REM  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_idx_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic [W2-1:0]     acc_q;
    logic [XLEN-1:0]   rd_q;
    logic              val_q;

    // Accept-side decode: signedness, magnitudes and special cases
    logic              w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_div0, w_ovf;
    logic [XLEN-1:0]   w_spec_res;

    assign w_a_signed = (i_op == c_MUL) | (i_op == c_MULH) | (i_op == 3'd2) |
                        (i_op == c_DIV) | (i_op == c_REM);
    assign w_b_signed = (i_op == c_MUL) | (i_op == c_MULH) |
                        (i_op == c_DIV) | (i_op == c_REM);
    assign w_sa       = w_a_signed & i_rs1[XLEN-1];
    assign w_sb       = w_b_signed & i_rs2[XLEN-1];
    assign w_abs_a    = w_sa ? (~i_rs1 + 1'b1) : i_rs1;
    assign w_abs_b    = w_sb ? (~i_rs2 + 1'b1) : i_rs2;
    assign w_neg      = (i_op == c_REM) ? w_sa : (w_sa ^ w_sb);
    assign w_div0     = i_op[2] & (i_rs2 == '0);
    assign w_ovf      = ((i_op == c_DIV) | (i_op == c_REM)) &
                        (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);
    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign w_spec_res = w_div0 ? (i_op[1] ? i_rs1 : '1)
                               : (i_op[1] ? '0 : i_rs1);

    assign hs_md4ex_rdy = (state_q == S_IDLE) & ~i_flush;
    assign hs_md4wb_val = val_q;
    assign o_rd         = rd_q;
    assign o_rd_idx     = rd_idx_q;

    // One iteration step: shift-add multiply or restoring divide
    logic [XLEN:0]     w_sum, w_r, w_diff;
    logic              w_ge;
    logic [W2-1:0]     w_mul_n, w_div_n, w_acc_n, w_prod_fix;
    logic [XLEN-1:0]   w_div_raw, w_div_fix, w_calc_res;

    assign w_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign w_mul_n = {w_sum, acc_q[XLEN-1:1]};
    assign w_r     = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    assign w_diff  = w_r - {1'b0, b_q};
    assign w_ge    = ~w_diff[XLEN];
    assign w_div_n = {(w_ge ? w_diff[XLEN-1:0] : w_r[XLEN-1:0]),
                      acc_q[XLEN-2:0], w_ge};
    assign w_acc_n = op_q[2] ? w_div_n : w_mul_n;

    assign w_prod_fix = neg_q ? (~w_acc_n + 1'b1) : w_acc_n;
    assign w_div_raw  = op_q[1] ? w_acc_n[W2-1:XLEN] : w_acc_n[XLEN-1:0];
    assign w_div_fix  = neg_q ? (~w_div_raw + 1'b1) : w_div_raw;
    assign w_calc_res = op_q[2]          ? w_div_fix :
                        (op_q == c_MUL)  ? w_prod_fix[XLEN-1:0] :
                                           w_prod_fix[W2-1:XLEN];

`ifdef CIRNO_MULDIV_FASTMUL_EN
    logic [W2-1:0]     w_fast_prod, w_fast_fix;
    logic [XLEN-1:0]   w_fast_res;

    assign w_fast_prod = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};
    assign w_fast_fix  = w_neg ? (~w_fast_prod + 1'b1) : w_fast_prod;
    assign w_fast_res  = (i_op == c_MUL) ? w_fast_fix[XLEN-1:0]
                                         : w_fast_fix[W2-1:XLEN];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_idx_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            rd_q     <= '0;
            val_q    <= 1'b0;
        end else if (i_flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hs_ex4md_val) begin
                        op_q     <= i_op;
                        rd_idx_q <= i_rd_idx;
                        a_q      <= w_abs_a;
                        b_q      <= w_abs_b;
                        neg_q    <= w_neg;
                        cnt_q    <= '0;
                        if (w_div0 | w_ovf) begin
                            rd_q    <= w_spec_res;
                            val_q   <= 1'b1;
                            state_q <= S_DONE;
`ifdef CIRNO_MULDIV_FASTMUL_EN
                        end else if (!i_op[2]) begin
                            rd_q    <= w_fast_res;
                            val_q   <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            // Divide seeds the dividend low; multiply the multiplier
                            acc_q   <= {{XLEN{1'b0}}, (i_op[2] ? w_abs_a : w_abs_b)};
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= w_acc_n;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        rd_q    <= w_calc_res;
                        val_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (hs_wb4md_rdy) begin
                        val_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    val_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exu_muldiv.sv
// ============================================================================
// Module   : tb_exu_muldiv
// Brief    : Self-checking bench for exu_muldiv (XLEN=32 and XLEN=64 instances)
//            against a plain-arithmetic RISC-V M-extension reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        ex_val = 1'b0, flush = 1'b0, wb_rdy = 1'b1;
    logic [2:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  idx = '0;
    logic        md_rdy, wb_val;
    logic [31:0] rd;
    logic [4:0]  rd_idx;

    logic        ex_val64 = 1'b0, flush64 = 1'b0, wb_rdy64 = 1'b1;
    logic [2:0]  op64 = '0;
    logic [63:0] rs1_64 = '0, rs2_64 = '0;
    logic [4:0]  idx64 = '0;
    logic        md_rdy64, wb_val64;
    logic [63:0] rd64;
    logic [4:0]  rd_idx64;

    always #5 clk = ~clk;

    exu_muldiv #(.XLEN(32), .CNT_W(7)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .hs_ex4md_val(ex_val), .hs_md4ex_rdy(md_rdy),
        .i_op(op), .i_rs1(rs1), .i_rs2(rs2), .i_rd_idx(idx), .i_flush(flush),
        .hs_md4wb_val(wb_val), .hs_wb4md_rdy(wb_rdy),
        .o_rd(rd), .o_rd_idx(rd_idx)
    );

    exu_muldiv #(.XLEN(64), .CNT_W(7)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .hs_ex4md_val(ex_val64), .hs_md4ex_rdy(md_rdy64),
        .i_op(op64), .i_rs1(rs1_64), .i_rs2(rs2_64), .i_rd_idx(idx64), .i_flush(flush64),
        .hs_md4wb_val(wb_val64), .hs_wb4md_rdy(wb_rdy64),
        .o_rd(rd64), .o_rd_idx(rd_idx64)
    );

    // Reference model: RISC-V M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a); sb = $signed(b);
        ua = {32'b0, a}; ub = {32'b0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [63:0] ref64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] minv;
        minv = 64'h8000_0000_0000_0000;
        case (f)
            3'd4: begin
                if (b == 0) return '1;
                if (a == minv && b == '1) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == minv && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, input int xl);
        logic [63:0] minv, ones;
        minv = (xl == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        ones = (xl == 32) ? 64'hFFFF_FFFF : '1;
        if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == minv && b == ones))) return 1;
`ifdef CIRNO_MULDIV_FASTMUL_EN
        if (!f[2]) return 1;
`endif
        return xl + 1;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, wait for the result and let it transfer (wb_rdy assumed 1)
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, output logic [31:0] res, output logic [4:0] ridx,
                          output int lat);
        int w;
        @(negedge clk);
        ex_val = 1'b1; op = f; rs1 = a; rs2 = b; idx = d;
        w = 0;
        while (!md_rdy && w < 200) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        ex_val = 1'b0; rs1 = $urandom; rs2 = $urandom; idx = 5'($urandom);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk); lat++;
            if (wb_val) break;
        end
        if (!wb_val) lat = -1;
        res = rd; ridx = rd_idx;
        @(posedge clk); #1;
    endtask

    task automatic run_op64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] d, output logic [63:0] res, output logic [4:0] ridx,
                            output int lat);
        int w;
        @(negedge clk);
        ex_val64 = 1'b1; op64 = f; rs1_64 = a; rs2_64 = b; idx64 = d;
        w = 0;
        while (!md_rdy64 && w < 200) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        ex_val64 = 1'b0; rs1_64 = {$urandom, $urandom}; rs2_64 = {$urandom, $urandom};
        lat = 0;
        while (lat < 200) begin
            @(negedge clk); lat++;
            if (wb_val64) break;
        end
        if (!wb_val64) lat = -1;
        res = rd64; ridx = rd_idx64;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (wb_val !== 1'b0 || rd !== 32'h0 || rd_idx !== 5'h0 || md_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset32: val=%b rd=%h idx=%0d rdy=%b, want val=0 rd=0 idx=0 rdy=1",
                     wb_val, rd, rd_idx, md_rdy);
        end
        checks++;
        if (wb_val64 !== 1'b0 || rd64 !== 64'h0 || rd_idx64 !== 5'h0) begin
            errors++;
            $display("FAIL reset64: val=%b rd=%h idx=%0d, want all 0", wb_val64, rd64, rd_idx64);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  f_t [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] a_t [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'sd7, -32'sd7,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_t [12] = '{-32'sd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e_t [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [31:0] res;
        logic [4:0]  ri;
        int          lat, el;
        for (int i = 0; i < 12; i++) begin
            run_op(f_t[i], a_t[i], b_t[i], 5'(i + 1), res, ri, lat);
            el = (i >= 8) ? 1 : ((i < 4) ? exp_lat(f_t[i], {32'b0, a_t[i]}, {32'b0, b_t[i]}, 32) : 33);
            checks++;
            if (res !== e_t[i] || ri !== 5'(i + 1) || lat != el) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d: rd=%h idx=%0d lat=%0d, want rd=%h idx=%0d lat=%0d",
                         i, f_t[i], res, ri, lat, e_t[i], i + 1, el);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, er;
        logic [4:0]  d, ri;
        int          lat, el;
        for (int i = 0; i < 48; i++) begin
            f = 3'(i % 8);
            a = pick32(); b = pick32(); d = 5'($urandom);
            er = ref32(f, a, b);
            el = exp_lat(f, {32'b0, a}, {32'b0, b}, 32);
            run_op(f, a, b, d, res, ri, lat);
            checks++;
            if (res !== er || ri !== d || lat != el) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h: rd=%h idx=%0d lat=%0d, want rd=%h idx=%0d lat=%0d",
                         f, a, b, res, ri, lat, er, d, el);
            end
        end
    endtask

    task automatic test_backpressure();
        int          w;
        logic [31:0] res;
        wb_rdy = 1'b0;
        @(negedge clk);
        ex_val = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; idx = 5'd9;
        @(posedge clk); #1;
        ex_val = 1'b0;
        w = 0;
        while (!wb_val && w < 100) begin @(negedge clk); w++; end
        // A new request sits waiting while the result is held
        ex_val = 1'b1; op = 3'd0; rs1 = 32'd6; rs2 = 32'd7; idx = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (wb_val !== 1'b1 || rd !== 32'd14 || rd_idx !== 5'd9 || md_rdy !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: val=%b rd=%h idx=%0d rdy=%b, want val=1 rd=e idx=9 rdy=0",
                         i, wb_val, rd, rd_idx, md_rdy);
            end
        end
        wb_rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (wb_val !== 1'b0 || md_rdy !== 1'b1) begin
            errors++;
            $display("FAIL release: val=%b rdy=%b, want val=0 rdy=1", wb_val, md_rdy);
        end
        @(posedge clk); #1;
        ex_val = 1'b0;
        w = 0;
        while (!wb_val && w < 100) begin @(negedge clk); w++; end
        res = rd;
        checks++;
        if (res !== 32'd42 || rd_idx !== 5'd3) begin
            errors++;
            $display("FAIL after_release: rd=%h idx=%0d, want rd=2a idx=3", res, rd_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0]  ri;
        int          lat;
        bit          seen;
        @(negedge clk);
        ex_val = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; idx = 5'd4;
        @(posedge clk); #1;
        ex_val = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (md_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_rdy: rdy=%b, want 0", md_rdy);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_val !== 1'b0 || md_rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: val=%b rdy=%b, want val=0 rdy=1", wb_val, md_rdy);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (wb_val) seen = 1'b1; end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_discard: val seen=1, want 0");
        end
        // Flush beats a simultaneous writeback handshake in DONE
        wb_rdy = 1'b0;
        @(negedge clk);
        ex_val = 1'b1; op = 3'd4; rs1 = 32'd5; rs2 = 32'd0; idx = 5'd2;
        @(posedge clk); #1;
        ex_val = 1'b0;
        @(negedge clk);
        flush = 1'b1; wb_rdy = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_val !== 1'b0 || md_rdy !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: val=%b rdy=%b, want val=0 rdy=1", wb_val, md_rdy);
        end
        run_op(3'd6, -32'sd7, 32'd2, 5'd8, res, ri, lat);
        checks++;
        if (res !== 32'hFFFF_FFFF || ri !== 5'd8 || lat != 33) begin
            errors++;
            $display("FAIL post_flush: rd=%h idx=%0d lat=%0d, want ffffffff 8 33", res, ri, lat);
        end
    endtask

    task automatic test_xlen64();
        logic [63:0] a, b, res, er;
        logic [4:0]  ri;
        int          lat, el;
        bit          seen;
        run_op64(3'd5, 64'h8000_0000_0000_0000, 64'd3, 5'd11, res, ri, lat);
        checks++;
        if (res !== 64'h2AAA_AAAA_AAAA_AAAA || ri !== 5'd11 || lat != 65) begin
            errors++;
            $display("FAIL divu64: rd=%h idx=%0d lat=%0d, want 2aaaaaaaaaaaaaaa 11 65", res, ri, lat);
        end
        for (int i = 0; i < 12; i++) begin
            a = {$urandom, $urandom};
            b = (i % 4 == 0) ? 64'd0 : ((i % 4 == 1) ? 64'(32'($urandom)) : {$urandom, $urandom});
            if (i == 6) begin a = 64'h8000_0000_0000_0000; b = '1; end
            er = ref64(3'(4 + i % 4), a, b);
            el = exp_lat(3'(4 + i % 4), a, b, 64);
            run_op64(3'(4 + i % 4), a, b, 5'(i), res, ri, lat);
            checks++;
            if (res !== er || ri !== 5'(i) || lat != el) begin
                errors++;
                $display("FAIL rand64 op=%0d a=%h b=%h: rd=%h lat=%0d, want rd=%h lat=%0d",
                         4 + i % 4, a, b, res, lat, er, el);
            end
        end
        @(negedge clk);
        ex_val64 = 1'b1; op64 = 3'd5; rs1_64 = 64'd12345; rs2_64 = 64'd7; idx64 = 5'd5;
        @(posedge clk); #1;
        ex_val64 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk); flush64 = 1'b1;
        @(posedge clk); #1; flush64 = 1'b0;
        seen = 1'b0;
        repeat (80) begin @(negedge clk); if (wb_val64) seen = 1'b1; end
        checks++;
        if (seen || md_rdy64 !== 1'b1) begin
            errors++;
            $display("FAIL flush64: val seen=%b rdy=%b, want 0 1", seen, md_rdy64);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic [63:0] res64;
        logic [4:0]  ri;
        int          lat;
        run_op(3'd5, 32'd100, 32'd7, 5'd9, res, ri, lat);
        run_op64(3'd5, 64'd100, 64'd7, 5'd9, res64, ri, lat);
        @(negedge clk);
        ex_val = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9; idx = 5'd17;
        ex_val64 = 1'b1; op64 = 3'd5; rs1_64 = 64'd99; rs2_64 = 64'd5; idx64 = 5'd17;
        @(posedge clk); #1;
        ex_val = 1'b0; ex_val64 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wb_val !== 1'b0 || rd !== 32'h0 || rd_idx !== 5'h0) begin
            errors++;
            $display("FAIL async_rst32: val=%b rd=%h idx=%0d, want 0 0 0", wb_val, rd, rd_idx);
        end
        checks++;
        if (wb_val64 !== 1'b0 || rd64 !== 64'h0 || rd_idx64 !== 5'h0) begin
            errors++;
            $display("FAIL async_rst64: val=%b rd=%h idx=%0d, want 0 0 0", wb_val64, rd64, rd_idx64);
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd30, res, ri, lat);
        checks++;
        if (res !== 32'h4000_0000 || ri !== 5'd30) begin
            errors++;
            $display("FAIL post_rst: rd=%h idx=%0d, want 40000000 30", res, ri);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_xlen64();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
